// File: rtl/hack_alu_driver.sv
// Hack C/A-instruction controller: owns A, D, PC; drives an external ALU; optional HACK_ALU_FLAG_CHECK_EN flag checker.
// Latency: A-instr ready again 2 cycles after accept, C-instr 3 cycles (EXEC + COMMIT_C).
// Backpressure: instr_ready is high only in IDLE; instr_valid is ignored while busy.
module hack_alu_driver #(
    parameter int              DATA_W   = 16,
    parameter int              PC_W     = 15,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    output logic              alu_zx,
    output logic              alu_nx,
    output logic              alu_zy,
    output logic              alu_ny,
    output logic              alu_f,
    output logic              alu_no,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_zr,
    input  logic              alu_ng,
    input  logic [DATA_W-1:0] inM,
    output logic [DATA_W-1:0] outM,
    output logic [PC_W-1:0]   addressM,
    output logic              writeM,
    output logic [PC_W-1:0]   pc,
    output logic              flag_err
);

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_COMMIT_C, S_COMMIT_A} state_t;

    state_t            state_q, state_d;
    logic [14:0]       ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d, d_q, d_d, res_q, res_d;
    logic              zr_q, zr_d, ng_q, ng_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic              jump;

`ifdef HACK_ALU_FLAG_CHECK_EN
    logic flag_err_q, flag_err_d;
    assign flag_err = flag_err_q;
`else
    assign flag_err = 1'b0;
`endif

    // Operands are steered continuously; only the control bits are gated to EXEC.
    assign alu_x    = d_q;
    assign alu_y    = ir_q[12] ? inM : a_q;
    assign addressM = a_q[PC_W-1:0];
    assign pc       = pc_q;

    always_comb begin
        state_d     = state_q;
        ir_d        = ir_q;
        a_d         = a_q;
        d_d         = d_q;
        res_d       = res_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        pc_d        = pc_q;
        instr_ready = 1'b0;
        alu_zx      = 1'b0;
        alu_nx      = 1'b0;
        alu_zy      = 1'b0;
        alu_ny      = 1'b0;
        alu_f       = 1'b0;
        alu_no      = 1'b0;
        writeM      = 1'b0;
        outM        = '0;
        jump        = 1'b0;
`ifdef HACK_ALU_FLAG_CHECK_EN
        flag_err_d  = flag_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d    = instr[14:0];
                    state_d = instr[15] ? S_EXEC : S_COMMIT_A;
                end
            end
            S_EXEC: begin
                {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no} = ir_q[11:6];
                res_d   = alu_out;
                zr_d    = alu_zr;
                ng_d    = alu_ng;
`ifdef HACK_ALU_FLAG_CHECK_EN
                if ((alu_zr != (alu_out == '0)) || (alu_ng != alu_out[DATA_W-1]))
                    flag_err_d = 1'b1;
`endif
                state_d = S_COMMIT_C;
            end
            S_COMMIT_C: begin
                // a_q is still the pre-commit A here, so address and jump target see the old value.
                writeM  = ir_q[3];
                outM    = ir_q[3] ? res_q : '0;
                if (ir_q[5]) a_d = res_q;
                if (ir_q[4]) d_d = res_q;
                jump    = (ir_q[2] && ng_q) || (ir_q[1] && zr_q) || (ir_q[0] && !zr_q && !ng_q);
                pc_d    = jump ? a_q[PC_W-1:0] : pc_q + 1'b1;
                state_d = S_IDLE;
            end
            S_COMMIT_A: begin
                a_d     = {1'b0, ir_q[14:0]};
                pc_d    = pc_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            ir_q       <= '0;
            a_q        <= '0;
            d_q        <= '0;
            res_q      <= '0;
            zr_q       <= 1'b0;
            ng_q       <= 1'b0;
            pc_q       <= RESET_PC;
`ifdef HACK_ALU_FLAG_CHECK_EN
            flag_err_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            a_q        <= a_d;
            d_q        <= d_d;
            res_q      <= res_d;
            zr_q       <= zr_d;
            ng_q       <= ng_d;
            pc_q       <= pc_d;
`ifdef HACK_ALU_FLAG_CHECK_EN
            flag_err_q <= flag_err_d;
`endif
        end
    end

endmodule

// File: tb/tb_hack_alu_driver.sv
// Randomised scoreboard bench for hack_alu_driver with a behavioural Hack machine model and ALU stub.
module tb_hack_alu_driver;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, instr_valid, instr_ready;
    logic [15:0] instr, alu_x, alu_y, alu_out, inM, outM;
    logic        alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no, alu_zr, alu_ng;
    logic [14:0] addressM, pc;
    logic        writeM, flag_err;
    logic        alu_fault;

    int checks = 0;
    int errors = 0;

    hack_alu_driver dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .alu_x(alu_x), .alu_y(alu_y),
        .alu_zx(alu_zx), .alu_nx(alu_nx), .alu_zy(alu_zy), .alu_ny(alu_ny),
        .alu_f(alu_f), .alu_no(alu_no), .alu_out(alu_out), .alu_zr(alu_zr),
        .alu_ng(alu_ng), .inM(inM), .outM(outM), .addressM(addressM),
        .writeM(writeM), .pc(pc), .flag_err(flag_err)
    );

    function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                              input logic [5:0] c);
        logic [15:0] xx, yy, o;
        xx = c[5] ? 16'h0 : x;
        xx = c[4] ? ~xx : xx;
        yy = c[3] ? 16'h0 : y;
        yy = c[2] ? ~yy : yy;
        o  = c[1] ? xx + yy : xx & yy;
        return c[0] ? ~o : o;
    endfunction

    assign alu_out = hack_alu(alu_x, alu_y, {alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no});
    assign alu_zr  = alu_fault ? 1'b0 : (alu_out == 16'h0);
    assign alu_ng  = alu_out[15];

    // Environment data memory (written by the DUT) and the model's own copy.
    logic [15:0] mem  [0:32767];
    logic [15:0] mmod [0:32767];
    assign inM = mem[addressM];
    always @(posedge clk) if (writeM === 1'b1) mem[addressM] <= outM;

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
    } st_t;
    st_t         sq[$];
    logic [30:0] wq[$];
    logic [15:0] ma, md;
    logic [14:0] mpc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: pops a memory-write expectation on each writeM cycle, and a
    // register/PC expectation each time the controller returns to ready.
    initial begin
        logic prev_rdy;
        logic [30:0] w;
        st_t s;
        prev_rdy = 1'b1;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                prev_rdy = 1'b1;
            end else begin
                if (writeM !== 1'b0) begin
                    if (wq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_writeM: got writeM=%b addr=0x%0h data=0x%0h, required no write",
                                 writeM, addressM, outM);
                    end else begin
                        w = wq.pop_front();
                        chk("addressM", {17'h0, addressM}, {17'h0, w[30:16]});
                        chk("outM", {16'h0, outM}, {16'h0, w[15:0]});
                    end
                end
                if (instr_ready === 1'b1 && !prev_rdy) begin
                    if (sq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_completion: got ready rise, required none pending");
                    end else begin
                        s = sq.pop_front();
                        chk("pc", {17'h0, pc}, {17'h0, s.pc});
                        chk("A_low", {17'h0, addressM}, {17'h0, s.a[14:0]});
                        chk("D", {16'h0, alu_x}, {16'h0, s.d});
                    end
                end
                prev_rdy = (instr_ready === 1'b1);
            end
        end
    end

    task automatic model_reset();
        ma  = 16'h0;
        md  = 16'h0;
        mpc = 15'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        instr_valid = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        instr_valid = 1'b0;
        model_reset();
    endtask

    task automatic issue(input logic [15:0] ins);
        logic [15:0] old_a, old_d, y, r;
        logic        jmp, is_c;
        int          busy;
        is_c  = ins[15];
        old_a = ma;
        old_d = md;
        y     = ins[12] ? mmod[ma[14:0]] : ma;
        r     = hack_alu(md, y, ins[11:6]);
        if (!is_c) begin
            ma  = {1'b0, ins[14:0]};
            mpc = mpc + 15'd1;
        end else begin
            jmp = (ins[2] && $signed(r) < 0) || (ins[1] && r == 16'h0) || (ins[0] && $signed(r) > 0);
            if (ins[3]) begin
                wq.push_back({old_a[14:0], r});
                mmod[old_a[14:0]] = r;
            end
            mpc = jmp ? old_a[14:0] : mpc + 15'd1;
            if (ins[5]) ma = r;
            if (ins[4]) md = r;
        end
        sq.push_back('{pc: mpc, a: ma, d: md});

        @(negedge clk);
        busy = 0;
        while (instr_ready !== 1'b1 && busy < 8) begin
            busy++;
            @(negedge clk);
        end
        if (busy >= 8) chk("ready_timeout_pre", 32'(instr_ready), 32'd1);
        instr = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1;
        // Garbage on the bus while busy must be ignored.
        instr = 16'($urandom);
        instr_valid = 1'($urandom_range(0, 1));
        busy = 0;
        forever begin
            @(negedge clk);
            if (instr_ready === 1'b1 || busy >= 8) break;
            busy++;
            if (is_c && busy == 1) begin
                chk("exec_ctrl", {26'h0, alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}, {26'h0, ins[11:6]});
                chk("exec_x", {16'h0, alu_x}, {16'h0, old_d});
                chk("exec_y", {16'h0, alu_y}, {16'h0, y});
            end
        end
        instr_valid = 1'b0;
        chk("busy_cycles", busy, is_c ? 32'd2 : 32'd1);
    endtask

    initial begin
        alu_fault   = 1'b0;
        rst_n       = 1'b0;
        instr_valid = 1'b1;
        instr       = 16'hEC10;
        for (int i = 0; i < 32768; i++) begin
            mem[i]  = 16'($urandom);
            mmod[i] = mem[i];
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", {17'h0, pc}, 32'h0);
        chk("rst_A", {17'h0, addressM}, 32'h0);
        chk("rst_D", {16'h0, alu_x}, 32'h0);
        chk("rst_writeM", {31'h0, writeM}, 32'h0);
        chk("rst_flag_err", {31'h0, flag_err}, 32'h0);
        rst_n       = 1'b1;
        instr_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);

        issue(16'h0005);
        issue(16'hEC10);
        chk("copy_pc", {17'h0, pc}, 32'd2);

        issue(16'd7);
        issue(16'hEC10);
        issue(16'd100);
        issue(16'hE7C8);
        chk("mw_mem", {16'h0, mem[100]}, 32'd8);

        issue(16'd42);
        issue(16'hEA90);
        issue(16'd42);
        issue(16'hE302);
        chk("jeq_taken_pc", {17'h0, pc}, 32'd42);
        issue(16'hEFD0);
        issue(16'd42);
        issue(16'hE302);
        chk("jeq_not_taken_pc", {17'h0, pc}, 32'd45);

        issue(16'h7FFF);
        issue(16'hEA87);
        chk("jmp_7fff", {17'h0, pc}, 32'h7FFF);
        issue(16'h0001);
        chk("pc_wrap", {17'h0, pc}, 32'h0);

        // Abort a C-instruction in EXEC.
        issue(16'd100);
        issue(16'hEFD0);
        @(negedge clk);
        instr = 16'hE7C8;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        chk("abort_pc", {17'h0, pc}, 32'h0);
        chk("abort_A", {17'h0, addressM}, 32'h0);
        chk("abort_D", {16'h0, alu_x}, 32'h0);
        chk("abort_ready", {31'h0, instr_ready}, 32'h1);

        alu_fault = 1'b1;
        issue(16'hEA90);
        alu_fault = 1'b0;
`ifdef HACK_ALU_FLAG_CHECK_EN
        chk("flag_err_set", {31'h0, flag_err}, 32'h1);
        issue(16'h0003);
        chk("flag_err_sticky", {31'h0, flag_err}, 32'h1);
        do_reset();
        @(negedge clk);
        chk("flag_err_cleared", {31'h0, flag_err}, 32'h0);
`else
        chk("flag_err_tied", {31'h0, flag_err}, 32'h0);
`endif

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 1) == 0) issue({1'b0, 15'($urandom)});
            else                            issue({3'b111, 13'($urandom)});
        end
        chk("flag_err_random", {31'h0, flag_err}, 32'h0);

        repeat (2) @(negedge clk);
        chk("sq_drained", sq.size(), 32'd0);
        chk("wq_drained", wq.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
